// File: rtl/regfile_hilo.sv
// regfile_hilo: architectural GPR file (2**AW x DW) plus the HI/LO pair.
// Commits the registered writeback bundle on the rising edge of clk. It provides two
// combinational GPR read ports and one HI/LO read port. r0 always reads as zero.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, the write data that is
// being committed this cycle is forwarded to the read ports in the same cycle.
module regfile_hilo #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_whilo,
  input  logic [DW-1:0] wb_hi,
  input  logic [DW-1:0] wb_lo,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [DW-1:0] regs_q [NumRegs];
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  // Forwarding hits. These are tied off when the bypass is not built in.
  logic byp1;
  logic byp2;
  logic byp_hilo;

`ifdef REGFILE_BYPASS_EN
  assign byp1     = wb_we && (wb_waddr == raddr1);
  assign byp2     = wb_we && (wb_waddr == raddr2);
  assign byp_hilo = wb_whilo;
`else
  assign byp1     = 1'b0;
  assign byp2     = 1'b0;
  assign byp_hilo = 1'b0;
`endif

  // GPR array. Reset clears every entry. Writes to r0 are dropped, so entry 0 stays zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we && (wb_waddr != '0)) begin
      regs_q[wb_waddr] <= wb_wdata;
    end
  end

  // HI/LO pair. Both halves are always written together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  // Read port 1. Priority order: reset, then enable, then r0, then bypass, then array.
  always_comb begin
    rdata1 = '0;
    if (reset_n && re1 && (raddr1 != '0)) begin
      rdata1 = byp1 ? wb_wdata : regs_q[raddr1];
    end
  end

  // Read port 2. It uses the same priority order as port 1 and is evaluated independently.
  always_comb begin
    rdata2 = '0;
    if (reset_n && re2 && (raddr2 != '0)) begin
      rdata2 = byp2 ? wb_wdata : regs_q[raddr2];
    end
  end

  // HI/LO read port. It is forced to zero in reset, and otherwise forwards or reads stored state.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (reset_n) begin
      hi_o = byp_hilo ? wb_hi : hi_q;
      lo_o = byp_hilo ? wb_lo : lo_q;
    end
  end

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo. A behavioural model (a plain array plus HI/LO)
// is checked against the DUT on every falling edge. Directed literal checks follow the
// test plan, and a randomized phase follows them.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regfile_hilo #(.DW(32), .AW(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .wb_whilo (wb_whilo),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  // Behavioural model of the architectural state.
  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_hi    <= 32'h0;
      m_lo    <= 32'h0;
      m_valid <= 1'b1;
    end else begin
      if (wb_we && wb_waddr != 5'd0) m_regs[wb_waddr] <= wb_wdata;
      if (wb_whilo) begin
        m_hi <= wb_hi;
        m_lo <= wb_lo;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (!reset_n || !en || a == 5'd0) return 32'h0;
    if (Bypass && wb_we && wb_waddr == a) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_hl(input bit hi_sel);
    if (!reset_n) return 32'h0;
    if (Bypass && wb_whilo) return hi_sel ? wb_hi : wb_lo;
    return hi_sel ? m_hi : m_lo;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, once the model state is defined or in reset.
  always @(negedge clk) begin
    if (m_valid || !reset_n) begin
      chk("cyc_rdata1", rdata1, exp_rd(re1, raddr1));
      chk("cyc_rdata2", rdata2, exp_rd(re2, raddr2));
      chk("cyc_hi", hi_o, exp_hl(1'b1));
      chk("cyc_lo", lo_o, exp_hl(1'b0));
    end
  end

  task automatic idle();
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
    wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v;

  initial begin
    reset_n = 1'b0;
    idle();
    tick();
    re1 = 1'b1; raddr1 = 5'd5;
    #1 chk("reset_read_zero", rdata1, 32'h0);
    tick();
    reset_n = 1'b1;
    idle();

    // Preload, then reset with a simultaneous write that must be discarded.
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234_5678;
    wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    #1 chk("preload_r5", rdata1, 32'h1234_5678);
    chk("preload_hi", hi_o, 32'hAAAA_0000);
    reset_n = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h5555_5555;
    tick();
    reset_n = 1'b1;
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    #1 chk("reset_r5", rdata1, 32'h0);
    chk("reset_hi", hi_o, 32'h0);

    // Basic write then read, then the disabled port.
    idle();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd7;
    #1 chk("r7_read", rdata1, 32'hDEAD_BEEF);
    re1 = 1'b0;
    #1 chk("r7_disabled", rdata1, 32'h0);

    // r0 protection.
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
    tick();
    idle();
    re2 = 1'b1; raddr2 = 5'd0;
    #1 chk("r0_zero", rdata2, 32'h0);

    // Same-cycle hazard on r3.
    idle();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1;
    tick();
    wb_wdata = 32'h2;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    #1 chk("hazard_p1_before", rdata1, Bypass ? 32'h2 : 32'h1);
    chk("hazard_p2_before", rdata2, Bypass ? 32'h2 : 32'h1);
    tick();
    wb_we = 1'b0;
    #1 chk("hazard_p1_after", rdata1, 32'h2);
    chk("hazard_p2_after", rdata2, 32'h2);

    // HI/LO written together with a GPR write.
    idle();
    wb_whilo = 1'b1; wb_hi = 32'h11; wb_lo = 32'h22;
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h99;
    #1 chk("hilo_same_hi", hi_o, Bypass ? 32'h11 : 32'h0);
    chk("hilo_same_lo", lo_o, Bypass ? 32'h22 : 32'h0);
    tick();
    idle();
    re1 = 1'b1; raddr1 = 5'd9;
    #1 chk("hilo_hi", hi_o, 32'h11);
    chk("hilo_lo", lo_o, 32'h22);
    chk("hilo_r9", rdata1, 32'h99);

    // Full sweep: write every register, then read (i, 32-i) pairs.
    idle();
    for (int i = 1; i < 32; i++) begin
      wb_we = 1'b1; wb_waddr = 5'(i); wb_wdata = i * 32'h0101_0101;
      tick();
    end
    idle();
    re1 = 1'b1; re2 = 1'b1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i);
      #1;
      v = i * 32'h0101_0101;
      chk("sweep_p1", rdata1, v);
      v = (32 - i) * 32'h0101_0101;
      chk("sweep_p2", rdata2, v);
      tick();
    end

    // Randomized phase. The per-cycle process does the checking.
    for (int n = 0; n < 2000; n++) begin
      reset_n  = ($urandom_range(0, 79) != 0);
      wb_we    = $urandom_range(0, 1) == 1;
      wb_waddr = 5'($urandom_range(0, 31));
      wb_wdata = $urandom;
      wb_whilo = $urandom_range(0, 2) == 0;
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = $urandom_range(0, 4) != 0;
      re2      = $urandom_range(0, 4) != 0;
      raddr1   = ($urandom_range(0, 2) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
      raddr2   = ($urandom_range(0, 2) == 0) ? wb_waddr : 5'($urandom_range(0, 31));
      tick();
    end

    reset_n = 1'b1;
    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
